// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types for the PLL reset sequencer: FSM state encoding
// and counter sizing helper.
package pll_reset_sequencer_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } seq_state_e;

    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_bit.sv
// Multi-flop synchroniser for a single asynchronous input bit,
// cleared asynchronously to 0.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Turns the asynchronous PLL lock flag into a clean, delayed reset
// for the PLL clock domain, and tracks lock-loss events.
module pll_reset_sequencer
    import pll_reset_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES   = 16,
    parameter int LOSS_CNT_W    = 8
) (
    input  logic                  clock_in,
    input  logic                  reset_n,
    input  logic                  pll_locked,
    output logic                  rst_out_n,
    output logic                  ready,
    output logic                  lock_lost,
    input  logic                  clear_lost,
    output logic [LOSS_CNT_W-1:0] loss_count
);

    localparam int CW = cnt_width(STABLE_CYCLES, HOLD_CYCLES);

    logic          lk;
    seq_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lost_event;

    sync_bit #(
        .STAGES(SYNC_STAGES)
    ) u_sync_lock (
        .clk  (clock_in),
        .rst_n(reset_n),
        .d    (pll_locked),
        .q    (lk)
    );

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lost_event = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                if (lk) begin
                    state_d = STABILIZE;
                    cnt_d   = '0;
                end
            end
            STABILIZE: begin
                if (!lk) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD: begin
                if (!lk) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RUN: begin
                if (!lk) begin
                    state_d    = WAIT_LOCK;
                    lost_event = 1'b1;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // A loss on the same edge as clear_lost must remain visible.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            lock_lost  <= 1'b0;
            loss_count <= '0;
        end else begin
            if (lost_event) begin
                lock_lost <= 1'b1;
            end else if (clear_lost) begin
                lock_lost <= 1'b0;
            end
            if (lost_event && (loss_count != '1)) begin
                loss_count <= loss_count + LOSS_CNT_W'(1);
            end
        end
    end

    assign rst_out_n = (state_q == RUN);
    assign ready     = rst_out_n;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Randomised + directed bench for pll_reset_sequencer against a
// run-length reference model of the synchronised lock flag.
module tb_pll_reset_sequencer;

    localparam int SYNC   = 2;
    localparam int STABLE = 8;
    localparam int HOLDC  = 4;
    localparam int W      = 3;
    localparam int RUN_AT = STABLE + HOLDC + 1;
    localparam int CMAX   = (1 << W) - 1;

    logic         clock_in = 1'b0;
    logic         reset_n;
    logic         pll_locked;
    logic         rst_out_n;
    logic         ready;
    logic         lock_lost;
    logic         clear_lost;
    logic [W-1:0] loss_count;

    int vectors = 0;
    int errs    = 0;

    bit hist[$];
    int run;
    bit m_lost;
    int m_cnt;

    pll_reset_sequencer #(
        .SYNC_STAGES  (SYNC),
        .STABLE_CYCLES(STABLE),
        .HOLD_CYCLES  (HOLDC),
        .LOSS_CNT_W   (W)
    ) dut (
        .clock_in  (clock_in),
        .reset_n   (reset_n),
        .pll_locked(pll_locked),
        .rst_out_n (rst_out_n),
        .ready     (ready),
        .lock_lost (lock_lost),
        .clear_lost(clear_lost),
        .loss_count(loss_count)
    );

    always #5 clock_in = ~clock_in;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t",
                   tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        hist.delete();
        run    = 0;
        m_lost = 1'b0;
        m_cnt  = 0;
    endfunction

    // Released iff the synced lock has been high for RUN_AT edges in a row.
    function automatic void model_edge(input bit pl, input bit clr);
        bit lk;
        bit was;
        hist.push_back(pl);
        if (hist.size() > 8) void'(hist.pop_front());
        lk  = (hist.size() > SYNC) ? hist[hist.size() - 1 - SYNC] : 1'b0;
        was = (run >= RUN_AT);
        if (lk) begin
            if (run < 1000) run++;
        end else begin
            run = 0;
        end
        if (was && !lk) begin
            m_lost = 1'b1;
            if (m_cnt < CMAX) m_cnt++;
        end else if (clr) begin
            m_lost = 1'b0;
        end
    endfunction

    task automatic check_model(input string where);
        chk({where, ":rst_out_n"}, rst_out_n, (run >= RUN_AT));
        chk({where, ":ready"}, ready, (run >= RUN_AT));
        chk({where, ":lock_lost"}, lock_lost, m_lost);
        chk({where, ":loss_count"}, loss_count, m_cnt);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic tick(input bit pl, input bit clr);
        pll_locked = pl;
        clear_lost = clr;
        @(posedge clock_in);
        model_edge(pl, clr);
        @(negedge clock_in);
        check_model("tick");
    endtask

    task automatic ticks(input int n, input bit pl);
        for (int i = 0; i < n; i++) tick(pl, 1'b0);
    endtask

    // Asserts reset between edges and checks outputs before any edge.
    task automatic do_reset(input string tag);
        #2;
        reset_n = 1'b0;
        #1;
        chk({tag, ":rst_out_n"}, rst_out_n, 1'b0);
        chk({tag, ":ready"}, ready, 1'b0);
        chk({tag, ":lock_lost"}, lock_lost, 1'b0);
        chk({tag, ":loss_count"}, loss_count, 0);
        model_reset();
        @(posedge clock_in);
        @(negedge clock_in);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        clear_lost = 1'b0;
        model_reset();
        @(negedge clock_in);
        do_reset("por");

        // Release latency from a clean reset.
        ticks(14, 1'b1);
        chk("t1_edge14_low", rst_out_n, 1'b0);
        tick(1'b1, 1'b0);
        chk("t1_edge15_high", rst_out_n, 1'b1);

        // Loss in RUN, then relock.
        ticks(2, 1'b0);
        chk("t2_edge2_still_run", ready, 1'b1);
        tick(1'b0, 1'b0);
        chk("t2_edge3_low", rst_out_n, 1'b0);
        chk("t2_lost", lock_lost, 1'b1);
        chk("t2_count", loss_count, 1);
        ticks(14, 1'b1);
        chk("t2_relock_14", ready, 1'b0);
        tick(1'b1, 1'b0);
        chk("t2_relock_15", ready, 1'b1);

        // One-cycle glitch while stabilising restarts the wait.
        do_reset("t3_rst");
        ticks(6, 1'b1);
        tick(1'b0, 1'b0);
        ticks(14, 1'b1);
        chk("t3_edge21_low", ready, 1'b0);
        tick(1'b1, 1'b0);
        chk("t3_edge22_high", ready, 1'b1);
        chk("t3_lost", lock_lost, 1'b0);
        chk("t3_count", loss_count, 0);

        // Nine losses saturate the counter.
        for (int k = 0; k < 9; k++) begin
            ticks(3, 1'b0);
            ticks(15, 1'b1);
        end
        chk("t4_sat", loss_count, CMAX);
        tick(1'b1, 1'b1);
        chk("t4_clr_lost", lock_lost, 1'b0);
        chk("t4_clr_count", loss_count, CMAX);

        // clear_lost coincident with a RUN loss.
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        chk("t5_set_wins", lock_lost, 1'b1);
        ticks(15, 1'b1);

        // Async reset mid-HOLD and mid-RUN.
        ticks(3, 1'b0);
        ticks(12, 1'b1);
        do_reset("t6_hold");
        ticks(14, 1'b1);
        chk("t6a_edge14", rst_out_n, 1'b0);
        tick(1'b1, 1'b0);
        chk("t6a_edge15", rst_out_n, 1'b1);
        ticks(5, 1'b1);
        do_reset("t6_run");
        ticks(14, 1'b1);
        chk("t6b_edge14", rst_out_n, 1'b0);
        tick(1'b1, 1'b0);
        chk("t6b_edge15", rst_out_n, 1'b1);

        // Random lock segments with sporadic clears.
        for (int s = 0; s < 60; s++) begin
            int len;
            bit lv;
            len = $urandom_range(1, 30);
            lv  = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < len; i++) begin
                tick(lv, ($urandom_range(0, 15) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
